led_sequencer: RTL and testbench
================================

LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter LED_W, default 16, SHALL set the LED pattern width.
REQ-002 Parameter PERIOD_W, default 24, SHALL set the width of the step-period counter.
REQ-003 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 s_address  input  2  SHALL be the config slave word address.
REQ-006 s_chipselect, s_write_n  input  1 each  SHALL qualify slave access; write = chipselect & ~write_n.
REQ-007 s_writedata  input  32  SHALL carry slave write data.
REQ-008 s_readdata  output  32  SHALL carry slave read data, combinational on s_address, zero-extended.
REQ-009 level  input  16  SHALL carry a signed audio sample.
REQ-010 level_valid  input  1  SHALL be a one-cycle strobe qualifying level.
REQ-011 m_address  output  2  SHALL be the PIO master address, tied to 0.
REQ-012 m_chipselect, m_write_n  output  1 each  SHALL form the master write request.
REQ-013 m_writedata  output  32  SHALL carry {zeros, pattern}.
REQ-014 m_waitrequest  input  1  SHALL stall the master write while high.

Function
REQ-015 Slave registers SHALL be: 0 CTRL (bit0 enable, bits2:1 mode), 1 PERIOD (PERIOD_W bits), 2 PATTERN (LED_W bits), 3 STATUS (read-only: bit0 busy, bits 31:16 current pattern).
REQ-016 Modes SHALL be: 0 static, 1 rotate-left, 2 blink, 3 level meter.
REQ-017 The prescaler SHALL count 0..PERIOD-1 while enabled and emit a one-cycle tick at PERIOD-1; PERIOD=0 SHALL behave as PERIOD=1.
REQ-018 On tick, rotate mode SHALL rotate the current pattern left by 1, with bit LED_W-1 wrapping to bit 0.
REQ-019 On tick, blink mode SHALL toggle the current pattern between PATTERN and zero.
REQ-020 Level mode SHALL, on each level_valid, latch n = min(LED_W, |level| >> 11) and form a thermometer with bits n-1..0 set; |-32768| SHALL saturate to 16 lit LEDs.
REQ-021 Level mode and static mode SHALL request a master write only when the computed pattern differs from the last written value.
REQ-022 Rotate and blink modes SHALL request a master write on every tick.
REQ-023 The FSM SHALL have states IDLE, RUN, WRITE:
- IDLE -> RUN on enable=1, loading the current pattern from PATTERN and requesting one write.
- RUN -> WRITE when a write is requested.
- WRITE holds m_chipselect=1 and m_write_n=0 with stable data until m_waitrequest=0, then -> RUN, or -> IDLE if enable=0.
- RUN -> IDLE on enable=0.
REQ-024 A write to CTRL, PERIOD or PATTERN while in WRITE SHALL NOT alter the in-flight transaction; new values SHALL take effect from the next cycle in RUN.
REQ-025 A write to PATTERN in RUN SHALL reload the current pattern, clear the prescaler and request a write on the next cycle.
REQ-026 A tick arriving in WRITE SHALL be held pending; at most one tick SHALL be held, and further ticks SHALL be dropped.
REQ-027 STATUS.busy SHALL equal (state == WRITE).
REQ-028 With m_waitrequest=0, first master-write latency SHALL be 2 cycles from the enable write.

Reset
REQ-029 Reset SHALL clear CTRL, PATTERN, the current pattern, the last-written value, the prescaler and the pending tick, and SHALL set PERIOD to 1.
REQ-030 Reset SHALL put the FSM in IDLE, drive m_chipselect=0, m_write_n=1 and m_writedata=0, and SHALL abort any in-flight write.

Structure
REQ-031 A shared package SHALL hold the mode encodings, register offsets, FSM state typedef and the level shift constant (11).
REQ-032 The prescaler SHALL be the sub-module led_seq_prescaler (inputs: enable, period, clear; output: tick).

Verification
REQ-033 PATTERN=0x0001, PERIOD=4, mode 1, enable -> writes 0x0001, 0x0002, 0x0004 at 4-cycle spacing; after 16 steps, 0x8000 wraps to 0x0001.
REQ-034 mode 2, PATTERN=0xA5A5, PERIOD=2 -> alternate writes 0xA5A5, 0x0000, 0xA5A5.
REQ-035 mode 3, level = 0x7FFF, 0x0800, 0x8000, 0x07FF -> writes 0x7FFF, 0x0001, 0xFFFF, 0x0000; a repeated level produces no write.
REQ-036 m_waitrequest held high 5 cycles during a write while PATTERN is rewritten -> data stays stable, STATUS.busy=1, then the new pattern is written next.
REQ-037 PERIOD=0, mode 1 -> a write every cycle pair with no hang.
REQ-038 reset_n asserted mid-WRITE -> m_chipselect=0 asynchronously; after release, FSM in IDLE and PERIOD reads 1.

Source files
------------

// File: rtl/led_sequencer_pkg.sv
// Shared definitions for the LED sequencer: register map, modes, FSM states
// and the audio-level to LED-count conversion.
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_LEVEL  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_PATTERN = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int unsigned LEVEL_SHIFT = 11;

  // |lvl| >> LEVEL_SHIFT; the 17-bit magnitude keeps -32768 from overflowing.
  function automatic logic [4:0] level_steps(input logic [15:0] lvl);
    logic [16:0] mag;
    mag = lvl[15] ? (17'd0 - {1'b1, lvl}) : {1'b0, lvl};
    return 5'(mag >> LEVEL_SHIFT);
  endfunction

endpackage

// File: rtl/led_sequencer_prescaler.sv
// Step-period prescaler: counts 0..period-1 while enabled and pulses tick on
// the last count. A period of zero behaves as one.
module led_seq_prescaler #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clear,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] last;

  // >= rather than == so shrinking PERIOD mid-count cannot strand the counter.
  always_comb begin
    last = (period == '0) ? '0 : period - 1'b1;
    tick = enable && (count >= last);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || !enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: config slave, step prescaler, pattern generation and
// a single-beat PIO master write of the current pattern.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int unsigned LED_W    = 16,
  parameter int unsigned PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  input  logic [15:0] level,
  input  logic        level_valid,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  state_e              state, state_next;
  logic                ctrl_enable;
  mode_e               ctrl_mode;
  logic [PERIOD_W-1:0] period_reg;
  logic [LED_W-1:0]    pattern_reg;
  logic [LED_W-1:0]    cur_pat;
  logic [LED_W-1:0]    last_wr;
  logic [LED_W-1:0]    wr_data;
  logic [4:0]          lvl_steps;
  logic                req, tick_pend, reload_pend;

  logic                s_wr, tick, tick_in, busy, stepping, presc_clear;
  logic                load_go, reload_go, issue, hold_tick;
  logic [LED_W-1:0]    thermo, stepped, target, issue_data;
  logic                unused_wdata;

  assign s_wr         = s_chipselect && !s_write_n;
  assign unused_wdata = ^s_writedata;
  assign tick_in      = tick || tick_pend;
  assign busy         = (state == ST_WRITE);
  assign stepping     = (ctrl_mode == MODE_ROTATE) || (ctrl_mode == MODE_BLINK);
  // Restarting the step timer whenever a load/reload is written keeps the
  // first step a full period after the first write.
  assign presc_clear  = (state == ST_IDLE) || reload_go || (issue && req);

  led_seq_prescaler #(.PERIOD_W(PERIOD_W)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (state != ST_IDLE),
    .period  (period_reg),
    .clear   (presc_clear),
    .tick    (tick)
  );

  always_comb begin
    thermo = '0;
    for (int unsigned i = 0; i < LED_W; i++) begin
      thermo[i] = (i < 32'(lvl_steps));
    end
    if (ctrl_mode == MODE_ROTATE) begin
      stepped = {cur_pat[LED_W-2:0], cur_pat[LED_W-1]};
    end else begin
      stepped = (cur_pat == '0) ? pattern_reg : '0;
    end
    target = (ctrl_mode == MODE_LEVEL) ? thermo : cur_pat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_go    = 1'b0;
    reload_go  = 1'b0;
    issue      = 1'b0;
    hold_tick  = 1'b0;
    issue_data = cur_pat;
    case (state)
      ST_IDLE: begin
        if (ctrl_enable) begin
          state_next = ST_RUN;
          load_go    = 1'b1;
        end
      end
      ST_RUN: begin
        if (!ctrl_enable) begin
          state_next = ST_IDLE;
        end else if (reload_pend) begin
          reload_go = 1'b1;
        end else if (req) begin
          issue     = 1'b1;
          hold_tick = tick_in;
        end else if (tick_in && stepping) begin
          issue      = 1'b1;
          issue_data = stepped;
        end else if (!stepping && (target != last_wr)) begin
          issue      = 1'b1;
          issue_data = target;
        end
        if (issue) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!m_waitrequest) begin
          state_next = ctrl_enable ? ST_RUN : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_enable <= 1'b0;
      ctrl_mode   <= MODE_STATIC;
      period_reg  <= PERIOD_W'(1);
      pattern_reg <= '0;
      cur_pat     <= '0;
      last_wr     <= '0;
      wr_data     <= '0;
      lvl_steps   <= '0;
      req         <= 1'b0;
      tick_pend   <= 1'b0;
      reload_pend <= 1'b0;
    end else begin
      if (level_valid) begin
        lvl_steps <= level_steps(level);
      end
      if (load_go || reload_go) begin
        cur_pat     <= pattern_reg;
        req         <= 1'b1;
        tick_pend   <= 1'b0;
        reload_pend <= 1'b0;
      end
      if (issue) begin
        wr_data   <= issue_data;
        last_wr   <= issue_data;
        cur_pat   <= issue_data;
        req       <= 1'b0;
        tick_pend <= hold_tick;
      end
      if (busy && tick) begin
        tick_pend <= 1'b1;
      end
      // Slave writes land last so a PATTERN write always leaves a reload pending.
      if (s_wr) begin
        case (s_address)
          REG_CTRL: begin
            ctrl_enable <= s_writedata[0];
            ctrl_mode   <= mode_e'(s_writedata[2:1]);
          end
          REG_PERIOD:  period_reg <= s_writedata[PERIOD_W-1:0];
          REG_PATTERN: begin
            pattern_reg <= s_writedata[LED_W-1:0];
            reload_pend <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    m_address    = '0;
    m_chipselect = busy;
    m_write_n    = !busy;
    m_writedata  = 32'(wr_data);
  end

  always_comb begin
    s_readdata = '0;
    case (s_address)
      REG_CTRL:    s_readdata = {29'd0, ctrl_mode, ctrl_enable};
      REG_PERIOD:  s_readdata = 32'(period_reg);
      REG_PATTERN: s_readdata = 32'(pattern_reg);
      default:     s_readdata = {16'(cur_pat), 15'd0, busy};
    endcase
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: register table, directed sequences and
// randomized rotate/level traffic against a behavioural model.
module tb_led_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  s_address;
  logic        s_chipselect, s_write_n;
  logic [31:0] s_writedata, s_readdata;
  logic [15:0] level;
  logic        level_valid;
  logic [1:0]  m_address;
  logic        m_chipselect, m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [31:0] wq[$];
  int          wt[$];

  led_sequencer #(.LED_W(16), .PERIOD_W(24)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .level(level), .level_valid(level_valid),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (reset_n && m_chipselect && !m_write_n && !m_waitrequest) begin
      wq.push_back(m_writedata);
      wt.push_back(cyc);
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  typedef struct { logic wr; logic [1:0] addr; logic [31:0] data; logic [31:0] exp; } reg_vec_t;
  typedef struct { logic [15:0] lvl; logic wr; logic [31:0] exp; } lvl_vec_t;
  reg_vec_t rv[10];
  lvl_vec_t lv[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sw(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
    @(posedge clk); #1;
    s_chipselect = 1'b0; s_write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    s_address = a;
    #1 d = s_readdata;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; s_address = '0; s_chipselect = 1'b0; s_write_n = 1'b1;
    s_writedata = '0; level = '0; level_valid = 1'b0; m_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    wq.delete(); wt.delete();
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    int k = 0;
    while (wq.size() < n && k < budget) begin
      @(posedge clk); k++;
    end
    #1 check(name, 32'(wq.size() >= n), 32'd1);
  endtask

  task automatic pulse_level(input logic [15:0] l);
    @(posedge clk); #1 level = l; level_valid = 1'b1;
    @(posedge clk); #1 level_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rotl16(input logic [15:0] p, input int k);
    int unsigned v = 32'(p);
    int s = k % 16;
    return ((v << s) | (v >> (16 - s))) & 32'hFFFF;
  endfunction

  function automatic logic [31:0] therm(input logic [15:0] l);
    int v = int'($signed(l));
    int n;
    logic [31:0] one = 32'd1;
    if (v < 0) v = -v;
    n = v / 2048;
    if (n > 16) n = 16;
    return (one << n) - 32'd1;
  endfunction

  initial begin
    logic [31:0] d, model_last, e;
    logic [15:0] p, l, prev;
    int k;

    rv[0] = '{1'b0, 2'd0, 32'h0, 32'h0};
    rv[1] = '{1'b0, 2'd1, 32'h0, 32'h1};
    rv[2] = '{1'b0, 2'd2, 32'h0, 32'h0};
    rv[3] = '{1'b0, 2'd3, 32'h0, 32'h0};
    rv[4] = '{1'b1, 2'd1, 32'h12345678, 32'h00345678};
    rv[5] = '{1'b1, 2'd2, 32'hDEADBEEF, 32'h0000BEEF};
    rv[6] = '{1'b1, 2'd0, 32'hFFFFFFF8, 32'h0};
    rv[7] = '{1'b1, 2'd0, 32'h00000006, 32'h6};
    rv[8] = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h0};
    rv[9] = '{1'b1, 2'd1, 32'h0, 32'h0};
    lv[0] = '{16'h7FFF, 1'b1, 32'h7FFF};
    lv[1] = '{16'h0800, 1'b1, 32'h0001};
    lv[2] = '{16'h8000, 1'b1, 32'hFFFF};
    lv[3] = '{16'h8000, 1'b0, 32'h0};
    lv[4] = '{16'h07FF, 1'b1, 32'h0000};
    lv[5] = '{16'hF800, 1'b1, 32'h0001};

    // Register map and reset values
    do_reset();
    check("reset_cs", 32'(m_chipselect), 32'd0);
    check("reset_wn", 32'(m_write_n), 32'd1);
    check("reset_wdata", m_writedata, 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (rv[i].wr) sw(rv[i].addr, rv[i].data);
      rd(rv[i].addr, d);
      check($sformatf("reg_vec%0d", i), d, rv[i].exp);
    end

    // First-write latency in static mode, then no repeat write
    do_reset();
    sw(2'd2, 32'h1234);
    sw(2'd0, 32'h1);
    @(negedge clk); check("lat_cyc1", 32'(m_chipselect), 32'd0);
    @(negedge clk); check("lat_cyc2", 32'(m_chipselect), 32'd0);
    @(negedge clk); check("lat_cs", 32'(m_chipselect), 32'd1);
    check("lat_data", m_writedata, 32'h1234);
    rd(2'd3, d); check("lat_status", d, 32'h12340001);
    repeat (10) @(posedge clk);
    #1 check("static_once", 32'(wq.size()), 32'd1);

    // Rotate, PERIOD=4, full wrap
    do_reset();
    sw(2'd2, 32'h1); sw(2'd1, 32'd4); sw(2'd0, 32'h3);
    wait_writes(18, 200, "rot_count");
    for (int i = 0; i < 18 && i < wq.size(); i++)
      check($sformatf("rot_w%0d", i), wq[i], rotl16(16'h1, i));
    if (wq.size() >= 3) begin
      check("rot_gap1", 32'(wt[1] - wt[0]), 32'd4);
      check("rot_gap2", 32'(wt[2] - wt[1]), 32'd4);
    end

    // Blink, PERIOD=2
    do_reset();
    sw(2'd2, 32'hA5A5); sw(2'd1, 32'd2); sw(2'd0, 32'h5);
    wait_writes(3, 50, "blink_count");
    if (wq.size() >= 3) begin
      check("blink_w0", wq[0], 32'hA5A5);
      check("blink_w1", wq[1], 32'h0000);
      check("blink_w2", wq[2], 32'hA5A5);
      check("blink_gap", 32'(wt[2] - wt[1]), 32'd2);
    end

    // Level meter: fixed table then randomized levels against the model
    do_reset();
    sw(2'd0, 32'h7);
    wait_writes(1, 20, "lvl_init");
    wq.delete();
    for (int i = 0; i < 6; i++) begin
      pulse_level(lv[i].lvl);
      check($sformatf("lvl_vec%0d_n", i), 32'(wq.size()), 32'(lv[i].wr));
      if (lv[i].wr && wq.size() > 0) check($sformatf("lvl_vec%0d", i), wq[0], lv[i].exp);
      wq.delete();
    end
    model_last = 32'h0001;
    prev = 16'hF800;
    for (int i = 0; i < 40; i++) begin
      l = ($urandom_range(0, 3) == 0) ? prev : 16'($urandom);
      prev = l;
      e = therm(l);
      pulse_level(l);
      check($sformatf("lvlr%0d_n", i), 32'(wq.size()), 32'(e != model_last));
      if (e != model_last && wq.size() > 0) check($sformatf("lvlr%0d", i), wq[0], e);
      model_last = e;
      wq.delete();
    end

    // Stall with PATTERN rewritten mid-transaction
    do_reset();
    sw(2'd2, 32'h1111);
    m_waitrequest = 1'b1;
    sw(2'd0, 32'h1);
    k = 0;
    while (!m_chipselect && k < 10) begin @(negedge clk); k++; end
    check("stall_cs", 32'(m_chipselect), 32'd1);
    sw(2'd2, 32'h2222);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_data%0d", i), m_writedata, 32'h1111);
      rd(2'd3, d);
      check($sformatf("stall_busy%0d", i), 32'(d[0]), 32'd1);
    end
    @(posedge clk); #1 m_waitrequest = 1'b0;
    wait_writes(2, 20, "stall_count");
    if (wq.size() >= 2) begin
      check("stall_w0", wq[0], 32'h1111);
      check("stall_w1", wq[1], 32'h2222);
    end

    // PERIOD=0 rotate: one write every two cycles
    do_reset();
    sw(2'd2, 32'h1); sw(2'd1, 32'd0); sw(2'd0, 32'h3);
    wait_writes(6, 40, "p0_count");
    for (int i = 0; i < 6 && i < wq.size(); i++) begin
      check($sformatf("p0_w%0d", i), wq[i], rotl16(16'h1, i));
      if (i > 0) check($sformatf("p0_gap%0d", i), 32'(wt[i] - wt[i-1]), 32'd2);
    end

    // Random rotate with random stalls and period
    do_reset();
    p = 16'($urandom_range(1, 16'hFFFF));
    sw(2'd2, 32'(p)); sw(2'd1, 32'($urandom_range(0, 3))); sw(2'd0, 32'h3);
    k = 0;
    while (wq.size() < 20 && k < 3000) begin
      @(posedge clk); #1 m_waitrequest = ($urandom_range(0, 2) == 0);
      k++;
    end
    m_waitrequest = 1'b0;
    check("rrot_count", 32'(wq.size() >= 20), 32'd1);
    for (int i = 0; i < 20 && i < wq.size(); i++)
      check($sformatf("rrot_w%0d", i), wq[i], rotl16(p, i));

    // Reset asserted mid-WRITE
    do_reset();
    sw(2'd2, 32'h00F0); sw(2'd1, 32'd7);
    m_waitrequest = 1'b1;
    sw(2'd0, 32'h1);
    k = 0;
    while (!m_chipselect && k < 10) begin @(negedge clk); k++; end
    check("rst_pre_cs", 32'(m_chipselect), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("rst_async_cs", 32'(m_chipselect), 32'd0);
    check("rst_async_wn", 32'(m_write_n), 32'd1);
    check("rst_async_data", m_writedata, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1; m_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_idle_cs", 32'(m_chipselect), 32'd0);
    rd(2'd3, d); check("rst_status", d, 32'd0);
    rd(2'd1, d); check("rst_period", d, 32'd1);
    rd(2'd0, d); check("rst_ctrl", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
